// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, LSB-first, start/data/stop framing.
// Samples each bit at its midpoint using the external s_tick enable.
module uart_rx #(
  parameter int unsigned DBIT    = 8,
  parameter int unsigned SB_TICK = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       s_tick,
  input  logic       rx,
  output logic [7:0] dout,
  output logic       rx_done_tick,
  output logic       frame_err
);

  localparam int unsigned SW = (SB_TICK > 16) ? 5 : 4;

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e            state_q, state_d;
  logic [SW-1:0]     s_cnt_q, s_cnt_d;
  logic [2:0]        n_cnt_q, n_cnt_d;
  logic [DBIT-1:0]   b_q, b_d;
  logic [7:0]        dout_q, dout_d;
  logic              ferr_q, ferr_d;
  logic              done_q, done_d;
  logic [1:0]        sync_q;
  logic              rx_s;

  // Synchronizer resets to the idle-high line level so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], rx};
    end
  end

  assign rx_s = sync_q[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      s_cnt_q <= '0;
      n_cnt_q <= '0;
      b_q     <= '0;
      dout_q  <= '0;
      ferr_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_cnt_q <= s_cnt_d;
      n_cnt_q <= n_cnt_d;
      b_q     <= b_d;
      dout_q  <= dout_d;
      ferr_q  <= ferr_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    s_cnt_d = s_cnt_q;
    n_cnt_d = n_cnt_q;
    b_d     = b_q;
    dout_d  = dout_q;
    ferr_d  = ferr_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!rx_s) begin
          state_d = StStart;
          s_cnt_d = '0;
        end
      end
      StStart: begin
        if (s_tick) begin
          if (s_cnt_q == SW'(7)) begin
            // Line back high at mid start bit: treat as a glitch.
            if (!rx_s) begin
              state_d = StData;
              s_cnt_d = '0;
              n_cnt_d = '0;
            end else begin
              state_d = StIdle;
            end
          end else begin
            s_cnt_d = s_cnt_q + 1'b1;
          end
        end
      end
      StData: begin
        if (s_tick) begin
          if (s_cnt_q == SW'(15)) begin
            s_cnt_d = '0;
            b_d     = {rx_s, b_q[DBIT-1:1]};
            if (n_cnt_q == 3'(DBIT - 1)) begin
              state_d = StStop;
            end else begin
              n_cnt_d = n_cnt_q + 1'b1;
            end
          end else begin
            s_cnt_d = s_cnt_q + 1'b1;
          end
        end
      end
      StStop: begin
        if (s_tick) begin
          if (s_cnt_q == SW'(SB_TICK - 1)) begin
            state_d = StIdle;
            dout_d  = 8'(b_q);
            ferr_d  = ~rx_s;
            done_d  = 1'b1;
          end else begin
            s_cnt_d = s_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign dout         = dout_q;
  assign frame_err    = ferr_q;
  assign rx_done_tick = done_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: table of frames plus glitch, back-to-back,
// stalled-tick and mid-frame reset sequences.
module tb_uart_rx;

  logic       clk;
  logic       reset;
  logic       s_tick;
  logic       rx;
  logic [7:0] dout;
  logic       rx_done_tick;
  logic       frame_err;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int dbl_cnt = 0;
  logic prev_done = 1'b0;
  logic [7:0] rec_dout[$];
  logic       rec_ferr[$];

  uart_rx #(.DBIT(8), .SB_TICK(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .s_tick       (s_tick),
    .rx           (rx),
    .dout         (dout),
    .rx_done_tick (rx_done_tick),
    .frame_err    (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse monitor, sampled on the inactive edge.
  always @(negedge clk) begin
    if (rx_done_tick) begin
      done_cnt++;
      rec_dout.push_back(dout);
      rec_ferr.push_back(frame_err);
      if (prev_done) dbl_cnt++;
    end
    prev_done = rx_done_tick;
  end

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic [7:0] exp_dout;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One s_tick pulse followed by three quiet clocks.
  task automatic tick();
    @(negedge clk) s_tick = 1'b1;
    @(negedge clk) s_tick = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic send_bits(input logic b, input int n);
    rx = b;
    repeat (n) tick();
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int stop_ticks);
    send_bits(1'b0, 16);
    for (int i = 0; i < 8; i++) send_bits(d[i], 16);
    send_bits(stop, stop_ticks);
    rx = 1'b1;
  endtask

  initial begin
    int base;
    int qb;
    logic [7:0] held;
    reset  = 1'b1;
    s_tick = 1'b0;
    rx     = 1'b1;

    vecs[0] = '{8'h55, 1'b1, 8'h55, 1'b0};
    vecs[1] = '{8'hA5, 1'b0, 8'hA5, 1'b1};
    vecs[2] = '{8'h00, 1'b1, 8'h00, 1'b0};
    vecs[3] = '{8'hFF, 1'b1, 8'hFF, 1'b0};
    vecs[4] = '{8'h80, 1'b0, 8'h80, 1'b1};
    vecs[5] = '{8'h01, 1'b1, 8'h01, 1'b0};
    vecs[6] = '{8'h3C, 1'b1, 8'h3C, 1'b0};

    repeat (3) @(negedge clk);
    check("reset_dout", 32'(dout), 32'h0);
    check("reset_ferr", 32'(frame_err), 32'h0);
    check("reset_done", 32'(rx_done_tick), 32'h0);
    reset = 1'b0;
    send_bits(1'b1, 4);

    for (int i = 0; i < 7; i++) begin
      base = done_cnt;
      send_frame(vecs[i].data, vecs[i].stop, 12);
      send_bits(1'b1, 20);
      check($sformatf("vec%0d_pulses", i), 32'(done_cnt - base), 32'd1);
      check($sformatf("vec%0d_dout", i), 32'(dout), 32'(vecs[i].exp_dout));
      check($sformatf("vec%0d_ferr", i), 32'(frame_err), 32'(vecs[i].exp_ferr));
    end

    // Short low glitch is rejected at mid start bit.
    base = done_cnt;
    held = dout;
    send_bits(1'b0, 4);
    send_bits(1'b1, 24);
    check("glitch_pulses", 32'(done_cnt - base), 32'd0);
    check("glitch_dout", 32'(dout), 32'(held));
    check("glitch_state_idle", 32'(dut.state_q), 32'(0));

    // Back-to-back frames with no idle gap between stop and next start.
    base = done_cnt;
    qb = rec_dout.size();
    send_frame(8'hA5, 1'b1, 16);
    send_frame(8'h3C, 1'b1, 16);
    send_bits(1'b1, 20);
    check("b2b_pulses", 32'(done_cnt - base), 32'd2);
    if (rec_dout.size() >= qb + 2) begin
      check("b2b_dout0", 32'(rec_dout[qb]), 32'hA5);
      check("b2b_ferr0", 32'(rec_ferr[qb]), 32'h0);
      check("b2b_dout1", 32'(rec_dout[qb+1]), 32'h3C);
      check("b2b_ferr1", 32'(rec_ferr[qb+1]), 32'h0);
    end

    // s_tick stalls for 100 clocks in the middle of data bit 4.
    base = done_cnt;
    begin
      logic [7:0] d;
      d = 8'hC6;
      send_bits(1'b0, 16);
      for (int i = 0; i < 8; i++) begin
        if (i == 4) begin
          send_bits(d[i], 8);
          repeat (100) @(negedge clk);
          send_bits(d[i], 8);
        end else begin
          send_bits(d[i], 16);
        end
      end
      send_bits(1'b1, 16);
    end
    send_bits(1'b1, 8);
    check("stall_pulses", 32'(done_cnt - base), 32'd1);
    check("stall_dout", 32'(dout), 32'hC6);
    check("stall_ferr", 32'(frame_err), 32'h0);

    // Reset during data bit 3 of a 0xFF frame.
    base = done_cnt;
    send_bits(1'b0, 16);
    for (int i = 0; i < 3; i++) send_bits(1'b1, 16);
    send_bits(1'b1, 8);
    reset = 1'b1;
    send_bits(1'b1, 2);
    reset = 1'b0;
    send_bits(1'b1, 40);
    check("rst_mid_pulses", 32'(done_cnt - base), 32'd0);
    check("rst_mid_dout", 32'(dout), 32'h0);
    check("rst_mid_ferr", 32'(frame_err), 32'h0);
    check("rst_mid_done", 32'(rx_done_tick), 32'h0);

    check("pulse_width", 32'(dbl_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
